pipeline_hazard_ctrl: RTL and testbench

//  Sequencer for the five pipeline segment registers (IF, ID, EX, MEM, WB).

---
 rtl/pipeline_hazard_if.sv | 56 +++++
 rtl/pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_if.sv
// Hazard-control bundle between the CPU datapath (master) and pipeline_hazard_ctrl (slave).
// Carries the stage register/decode fields in and the per-segment stall/flush/forward controls out.
interface pipeline_hazard_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       rs1_d;
   logic [4:0]       rs2_d;
   logic [4:0]       rs1_e;
   logic [4:0]       rs2_e;
   logic [4:0]       rd_e;
   logic [4:0]       rd_m;
   logic [4:0]       rd_w;
   logic [1:0]       reg_read_d;
   logic [1:0]       reg_read_e;
   logic [2:0]       reg_write_e;
   logic [2:0]       reg_write_m;
   logic [2:0]       reg_write_w;
   logic             mem_to_reg_e;
   logic             branch_e;
   logic             jalr_e;
   logic             jal_d;
   logic             mem_req_m;
   logic             mem_ready_m;

   logic             stall_f;
   logic             stall_d;
   logic             stall_e;
   logic             stall_m;
   logic             stall_w;
   logic             flush_f;
   logic             flush_d;
   logic             flush_e;
   logic             flush_m;
   logic             flush_w;
   logic [1:0]       forward1_e;
   logic [1:0]       forward2_e;
   logic             busy;
   logic             err;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, reg_read_d, reg_read_e,
             reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, branch_e, jalr_e, jal_d,
             mem_req_m, mem_ready_m,
      input  stall_f, stall_d, stall_e, stall_m, stall_w, flush_f, flush_d, flush_e, flush_m,
             flush_w, forward1_e, forward2_e, busy, err, stall_cnt
   );

   modport slave (
      input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, reg_read_d, reg_read_e,
             reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, branch_e, jalr_e, jal_d,
             mem_req_m, mem_ready_m,
      output stall_f, stall_d, stall_e, stall_m, stall_w, flush_f, flush_d, flush_e, flush_m,
             flush_w, forward1_e, forward2_e, busy, err, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard sequencer: stall/flush per segment, EX forwarding, memory-wait timeout.
// Define HAZARD_FORWARD_EN for EX forwarding; otherwise RAW hazards on EX/MEM producers stall instead.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned INIT_FLUSH  = 2,
   parameter int unsigned CNT_W       = 32
) (
   input logic              clk,
   input logic              rst,
   pipeline_hazard_if.slave hz
);

   localparam int unsigned CntMax = (MEM_TIMEOUT > INIT_FLUSH) ? MEM_TIMEOUT : INIT_FLUSH;
   localparam int unsigned TW     = $clog2(CntMax + 1) + 1;
   localparam logic [TW-1:0] InitLast    = TW'(INIT_FLUSH - 1);
   localparam logic [TW-1:0] TimeoutLast = TW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {StInit, StRun, StMemWait, StErr} state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Bit 4 = F ... bit 0 = W.
   logic [4:0] stall;
   logic [4:0] flush;
   logic [1:0] fwd1, fwd2;
   logic       resolve;
   logic       load_use;

   function automatic logic src_hit(input logic used, input logic [4:0] src,
                                    input logic [4:0] rd, input logic [2:0] we);
      return used && (we != 3'd0) && (rd != 5'd0) && (src == rd);
   endfunction

`ifdef HAZARD_FORWARD_EN
   always_comb begin
      load_use = hz.mem_to_reg_e &&
                 (src_hit(hz.reg_read_d[1], hz.rs1_d, hz.rd_e, hz.reg_write_e) ||
                  src_hit(hz.reg_read_d[0], hz.rs2_d, hz.rd_e, hz.reg_write_e));
      fwd1 = 2'b00;
      fwd2 = 2'b00;
      if (src_hit(hz.reg_read_e[1], hz.rs1_e, hz.rd_m, hz.reg_write_m)) begin
         fwd1 = 2'b10;
      end else if (src_hit(hz.reg_read_e[1], hz.rs1_e, hz.rd_w, hz.reg_write_w)) begin
         fwd1 = 2'b01;
      end
      if (src_hit(hz.reg_read_e[0], hz.rs2_e, hz.rd_m, hz.reg_write_m)) begin
         fwd2 = 2'b10;
      end else if (src_hit(hz.reg_read_e[0], hz.rs2_e, hz.rd_w, hz.reg_write_w)) begin
         fwd2 = 2'b01;
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{hz.rs1_e, hz.rs2_e, hz.reg_read_e, hz.rd_w, hz.reg_write_w,
                         hz.mem_to_reg_e};

   // Without forwarding any in-flight producer of a used ID source must drain first.
   always_comb begin
      load_use = src_hit(hz.reg_read_d[1], hz.rs1_d, hz.rd_e, hz.reg_write_e) ||
                 src_hit(hz.reg_read_d[0], hz.rs2_d, hz.rd_e, hz.reg_write_e) ||
                 src_hit(hz.reg_read_d[1], hz.rs1_d, hz.rd_m, hz.reg_write_m) ||
                 src_hit(hz.reg_read_d[0], hz.rs2_d, hz.rd_m, hz.reg_write_m);
      fwd1 = 2'b00;
      fwd2 = 2'b00;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 5'b00000;
      flush   = 5'b00000;
      resolve = 1'b0;

      unique case (state_q)
         StInit: begin
            stall = 5'b10000;
            flush = 5'b01111;
            if (cnt_q == InitLast) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         StRun: begin
            if (hz.mem_req_m && !hz.mem_ready_m) begin
               stall   = 5'b11110;
               flush   = 5'b00001;
               cnt_d   = TW'(1);
               state_d = (MEM_TIMEOUT <= 1) ? StErr : StMemWait;
            end else begin
               resolve = 1'b1;
            end
         end
         StMemWait: begin
            if (!hz.mem_ready_m) begin
               stall = 5'b11110;
               flush = 5'b00001;
               cnt_d = cnt_q + TW'(1);
               if (cnt_q == TimeoutLast) begin
                  state_d = StErr;
               end
            end else begin
               // Release: the frozen EX/ID pair is re-evaluated in this same cycle.
               cnt_d   = '0;
               state_d = StRun;
               resolve = 1'b1;
            end
         end
         StErr: begin
            stall = 5'b11110;
            flush = 5'b00001;
         end
         default: begin
            state_d = StErr;
         end
      endcase

      if (resolve) begin
         if (hz.branch_e || hz.jalr_e) begin
            flush = 5'b01100;
         end else if (load_use) begin
            stall = 5'b11000;
            flush = 5'b00100;
         end else if (hz.jal_d) begin
            flush = 5'b01000;
         end
      end

      if (rst) begin
         stall = 5'b00000;
         flush = 5'b01111;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall[4] && (state_q != StInit) && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall_f    = stall[4];
   assign hz.stall_d    = stall[3];
   assign hz.stall_e    = stall[2];
   assign hz.stall_m    = stall[1];
   assign hz.stall_w    = stall[0];
   assign hz.flush_f    = flush[4];
   assign hz.flush_d    = flush[3];
   assign hz.flush_e    = flush[2];
   assign hz.flush_m    = flush[1];
   assign hz.flush_w    = flush[0];
   assign hz.forward1_e = rst ? 2'b00 : fwd1;
   assign hz.forward2_e = rst ? 2'b00 : fwd2;
   assign hz.busy       = (state_q != StRun);
   assign hz.err        = (state_q == StErr);
   assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vectors, multi-cycle sequences and a
// randomized run checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned TO    = 4;
   localparam int unsigned INITF = 2;
   localparam int unsigned CW    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   pipeline_hazard_if #(.CNT_W(CW)) bus ();

   pipeline_hazard_ctrl #(
      .MEM_TIMEOUT(TO),
      .INIT_FLUSH (INITF),
      .CNT_W      (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, act=running req=finished");
      $fatal(1, "watchdog");
   end

   // Reference model: mode 0 init, 1 run, 2 memory wait, 3 error.
   int m_mode = 0;
   int m_init_cycles = 0;
   int m_waits = 0;
   int m_stalls = 0;
   logic [9:0] exp_ctrl;

   // Last sampled DUT outputs.
   logic [9:0]    obs_ctrl;
   logic [1:0]    obs_f1, obs_f2;
   logic          obs_busy, obs_err;
   logic [CW-1:0] obs_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: act=%0h req=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic hit(input logic used, input logic [4:0] src, input logic [4:0] rd,
                                input logic [2:0] we);
      return used && we != 0 && rd != 0 && src == rd;
   endfunction

   function automatic logic [1:0] model_fwd(input logic used, input logic [4:0] src);
`ifdef HAZARD_FORWARD_EN
      if (hit(used, src, bus.rd_m, bus.reg_write_m)) return 2'b10;
      if (hit(used, src, bus.rd_w, bus.reg_write_w)) return 2'b01;
`endif
      return 2'b00;
   endfunction

   function automatic logic model_raw();
      logic [4:0] src [2];
      logic       used [2];
      logic       dep;
      src[0] = bus.rs1_d; used[0] = bus.reg_read_d[1];
      src[1] = bus.rs2_d; used[1] = bus.reg_read_d[0];
      dep = 1'b0;
      for (int i = 0; i < 2; i++) begin
`ifdef HAZARD_FORWARD_EN
         if (bus.mem_to_reg_e && hit(used[i], src[i], bus.rd_e, bus.reg_write_e)) dep = 1'b1;
`else
         if (hit(used[i], src[i], bus.rd_e, bus.reg_write_e)) dep = 1'b1;
         if (hit(used[i], src[i], bus.rd_m, bus.reg_write_m)) dep = 1'b1;
`endif
      end
      return dep;
   endfunction

   // Inputs are already applied (at a falling edge); sample, compare to model, advance one clock.
   task automatic step();
      logic       hold;
      logic [1:0] ef1, ef2;
      logic       ebusy, eerr;
      #1;
      if (rst) begin
         m_mode = 0; m_init_cycles = 0; m_waits = 0; m_stalls = 0;
      end
      hold = (m_mode == 3) || (m_mode == 2 && !bus.mem_ready_m) ||
             (m_mode == 1 && bus.mem_req_m && !bus.mem_ready_m);
      if (rst)               exp_ctrl = 10'b00000_01111;
      else if (m_mode == 0)  exp_ctrl = 10'b10000_01111;
      else if (hold)         exp_ctrl = 10'b11110_00001;
      else if (bus.branch_e || bus.jalr_e) exp_ctrl = 10'b00000_01100;
      else if (model_raw())  exp_ctrl = 10'b11000_00100;
      else if (bus.jal_d)    exp_ctrl = 10'b00000_01000;
      else                   exp_ctrl = 10'b00000_00000;
      ef1   = rst ? 2'b00 : model_fwd(bus.reg_read_e[1], bus.rs1_e);
      ef2   = rst ? 2'b00 : model_fwd(bus.reg_read_e[0], bus.rs2_e);
      ebusy = rst || m_mode != 1;
      eerr  = !rst && m_mode == 3;

      obs_ctrl = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w,
                  bus.flush_f, bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w};
      obs_f1 = bus.forward1_e; obs_f2 = bus.forward2_e;
      obs_busy = bus.busy; obs_err = bus.err; obs_cnt = bus.stall_cnt;
      check("model", {8'd0, obs_ctrl, obs_f1, obs_f2, obs_busy, obs_err, obs_cnt},
            {8'd0, exp_ctrl, ef1, ef2, ebusy, eerr, 8'(m_stalls)});

      @(posedge clk);
      if (!rst) begin
         if (exp_ctrl[9] && m_mode != 0 && m_stalls < 255) m_stalls++;
         case (m_mode)
            0: begin
               m_init_cycles++;
               if (m_init_cycles == INITF) m_mode = 1;
            end
            1: if (bus.mem_req_m && !bus.mem_ready_m) begin
               m_waits = 1;
               m_mode  = (m_waits >= TO) ? 3 : 2;
            end
            2: if (bus.mem_ready_m) m_mode = 1;
               else begin
                  m_waits++;
                  if (m_waits >= TO) m_mode = 3;
               end
            default: ;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.rs1_d = 0; bus.rs2_d = 0; bus.rs1_e = 0; bus.rs2_e = 0;
      bus.rd_e = 0; bus.rd_m = 0; bus.rd_w = 0;
      bus.reg_read_d = 0; bus.reg_read_e = 0;
      bus.reg_write_e = 0; bus.reg_write_m = 0; bus.reg_write_w = 0;
      bus.mem_to_reg_e = 0; bus.branch_e = 0; bus.jalr_e = 0; bus.jal_d = 0;
      bus.mem_req_m = 0; bus.mem_ready_m = 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < int'(INITF); i++) step();
   endtask

   typedef struct {
      logic [4:0] rs1_d, rs2_d, rd_e, rd_m;
      logic [1:0] rr_d;
      logic [2:0] we_e, we_m;
      logic       load_e, br_e, jalr_e, jal_d;
      logic [9:0] exp;
   } vec_t;

   localparam logic [9:0] CLu  = 10'b11000_00100;
   localparam logic [9:0] CNone = 10'b00000_00000;

   vec_t vecs [10];

   initial begin
      //           rs1 rs2 rdE rdM rrD   weE weM ld br jr jd  expected
      vecs[0] = '{5, 0, 5, 0, 2'b10, 1, 0, 1, 0, 0, 0, CLu};
      vecs[1] = '{5, 0, 5, 0, 2'b01, 1, 0, 1, 0, 0, 0, CNone};
      vecs[2] = '{0, 5, 5, 0, 2'b01, 1, 0, 1, 0, 0, 0, CLu};
      vecs[3] = '{0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 0, 0, CNone};
      vecs[4] = '{5, 0, 5, 0, 2'b10, 0, 0, 1, 0, 0, 0, CNone};
      vecs[5] = '{0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 10'b00000_01000};
      vecs[6] = '{5, 0, 5, 0, 2'b10, 1, 0, 1, 0, 1, 0, 10'b00000_01100};
      vecs[8] = '{9, 0, 9, 0, 2'b10, 4, 0, 1, 0, 0, 1, CLu};
`ifdef HAZARD_FORWARD_EN
      vecs[7] = '{5, 0, 5, 0, 2'b10, 2, 0, 0, 0, 0, 0, CNone};
      vecs[9] = '{0, 6, 0, 6, 2'b01, 0, 1, 0, 0, 0, 0, CNone};
`else
      vecs[7] = '{5, 0, 5, 0, 2'b10, 2, 0, 0, 0, 0, 0, CLu};
      vecs[9] = '{0, 6, 0, 6, 2'b01, 0, 1, 0, 0, 0, 0, CLu};
`endif

      clear_inputs();
      @(negedge clk);

      // T1: reset held 3 cycles, then INIT_FLUSH cycles of flush, then idle RUN.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_ctrl", 32'(obs_ctrl), 32'(10'b00000_01111));
         check("rst_busy", 32'(obs_busy), 32'd1);
      end
      check("rst_cnt", 32'(obs_cnt), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < int'(INITF); i++) begin
         step();
         check("init_ctrl", 32'(obs_ctrl), 32'(10'b10000_01111));
      end
      step();
      check("run_ctrl", 32'(obs_ctrl), 32'(CNone));
      check("run_busy", 32'(obs_busy), 32'd0);
      check("init_not_counted", 32'(obs_cnt), 32'd0);

      // T2: load-use for one cycle, counted once.
      bus.rd_e = 5; bus.mem_to_reg_e = 1; bus.reg_write_e = 1; bus.rs1_d = 5; bus.reg_read_d = 2'b10;
      step();
      check("lu_ctrl", 32'(obs_ctrl), 32'(CLu));
      clear_inputs();
      step();
      check("lu_done", 32'(obs_ctrl), 32'(CNone));
      check("lu_cnt", 32'(obs_cnt), 32'd1);

      // T3: taken branch beats the load-use.
      bus.rd_e = 5; bus.mem_to_reg_e = 1; bus.reg_write_e = 1; bus.rs1_d = 5; bus.reg_read_d = 2'b10;
      bus.branch_e = 1;
      step();
      check("br_ctrl", 32'(obs_ctrl), 32'(10'b00000_01100));
      clear_inputs();

      // Directed vector table.
      foreach (vecs[i]) begin
         bus.rs1_d = vecs[i].rs1_d; bus.rs2_d = vecs[i].rs2_d;
         bus.rd_e = vecs[i].rd_e; bus.rd_m = vecs[i].rd_m; bus.reg_read_d = vecs[i].rr_d;
         bus.reg_write_e = vecs[i].we_e; bus.reg_write_m = vecs[i].we_m;
         bus.mem_to_reg_e = vecs[i].load_e; bus.branch_e = vecs[i].br_e;
         bus.jalr_e = vecs[i].jalr_e; bus.jal_d = vecs[i].jal_d;
         step();
         check($sformatf("vec%0d", i), 32'(obs_ctrl), 32'(vecs[i].exp));
         clear_inputs();
      end

      // T4: three wait cycles with a pending branch frozen, then release.
      bus.mem_req_m = 1; bus.mem_ready_m = 0; bus.branch_e = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("wait_ctrl", 32'(obs_ctrl), 32'(10'b11110_00001));
         check("wait_busy", 32'(obs_busy), (i == 0) ? 32'd0 : 32'd1);
      end
      bus.mem_ready_m = 1; bus.branch_e = 0;
      step();
      check("release_ctrl", 32'(obs_ctrl), 32'(CNone));
      check("release_busy", 32'(obs_busy), 32'd1);
      clear_inputs();
      step();
      check("after_release_busy", 32'(obs_busy), 32'd0);

      // T5: forwarding selects, or the widened RAW stall without forwarding.
      bus.rd_m = 7; bus.rd_w = 7; bus.reg_write_m = 1; bus.reg_write_w = 1;
      bus.rs1_e = 7; bus.reg_read_e = 2'b10;
      step();
`ifdef HAZARD_FORWARD_EN
      check("fwd_mem", 32'(obs_f1), 32'(2'b10));
      bus.reg_write_m = 0;
      step();
      check("fwd_wb", 32'(obs_f1), 32'(2'b01));
`else
      check("fwd_off", 32'(obs_f1), 32'(2'b00));
      bus.rs1_d = 7; bus.reg_read_d = 2'b10;
      step();
      check("raw_mem_stall", 32'(obs_ctrl), 32'(CLu));
`endif
      clear_inputs();

      // T6: timeout into sticky ERR, counter saturation, reset exit.
      bus.mem_req_m = 1; bus.mem_ready_m = 0;
      for (int i = 0; i < int'(TO); i++) begin
         step();
         check("pre_err", 32'(obs_err), 32'd0);
      end
      step();
      check("err_set", 32'(obs_err), 32'd1);
      bus.mem_ready_m = 1;
      step();
      check("err_sticky", 32'(obs_err), 32'd1);
      check("err_ctrl", 32'(obs_ctrl), 32'(10'b11110_00001));
      for (int i = 0; i < 260; i++) begin
         bus.mem_ready_m = 1'($urandom);
         step();
      end
      check("cnt_saturated", 32'(obs_cnt), 32'd255);
      clear_inputs();
      rst = 1'b1;
      step();
      check("err_cleared", 32'(obs_err), 32'd0);
      check("cnt_cleared", 32'(obs_cnt), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < int'(INITF); i++) step();

      // Randomized traffic on a small register space to force frequent matches.
      for (int i = 0; i < 600; i++) begin
         bus.rs1_d = 5'($urandom_range(0, 3)); bus.rs2_d = 5'($urandom_range(0, 3));
         bus.rs1_e = 5'($urandom_range(0, 3)); bus.rs2_e = 5'($urandom_range(0, 3));
         bus.rd_e = 5'($urandom_range(0, 3)); bus.rd_m = 5'($urandom_range(0, 3));
         bus.rd_w = 5'($urandom_range(0, 3));
         bus.reg_read_d = 2'($urandom); bus.reg_read_e = 2'($urandom);
         bus.reg_write_e = 3'($urandom); bus.reg_write_m = 3'($urandom);
         bus.reg_write_w = 3'($urandom);
         bus.mem_to_reg_e = 1'($urandom);
         bus.branch_e = ($urandom_range(0, 5) == 0);
         bus.jalr_e = ($urandom_range(0, 7) == 0);
         bus.jal_d = ($urandom_range(0, 5) == 0);
         bus.mem_req_m = ($urandom_range(0, 3) == 0);
         bus.mem_ready_m = ($urandom_range(0, 2) != 0);
         rst = (i % 90 == 89);
         step();
      end
      rst = 1'b0;
      clear_inputs();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
